// File: rtl/decoder_seq_pkg.sv
// Shared definitions for the decoder address sequencer: FSM encoding and default widths.
package decoder_seq_pkg;

    localparam int unsigned ADDR_W_DEF  = 6;
    localparam int unsigned DWELL_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/dwell_timer.sv
// Per-address dwell timer: loads max(load_val,1) and flags the final dwell cycle.
module dwell_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;

    // Countdown; expire is registered so it is high exactly while cnt==1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            expire <= 1'b0;
        end else if (load) begin
            cnt    <= (load_val == '0) ? W'(1) : load_val;
            expire <= (load_val <= W'(1));
        end else if (dec && (cnt != '0)) begin
            cnt    <= cnt - W'(1);
            expire <= (cnt == W'(2));
        end
    end

endmodule

// File: rtl/decoder_addr_sequencer.sv
// Drives en/a for the 6x64 one-hot decoder, stepping first..last (ascending, modulo
// 2**ADDR_W) with a programmable dwell and optional one-cycle blanking between lines.
module decoder_addr_sequencer
    import decoder_seq_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DWELL_W = DWELL_W_DEF,
    parameter bit          GAP_EN  = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [ADDR_W-1:0]  first_addr,
    input  logic [ADDR_W-1:0]  last_addr,
    input  logic [DWELL_W-1:0] dwell,
    output logic               en,
    output logic [ADDR_W-1:0]  a,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   first_q, last_q;
    logic [DWELL_W-1:0]  dwell_q;
    logic                cont_q;

    logic                en_d, done_d, wrap_d, cap_c;
    logic [ADDR_W-1:0]   a_d, nxt_addr_c;
    logic                tmr_load_c, tmr_dec_c, tmr_expire;
    logic [DWELL_W-1:0]  tmr_val_c;

    dwell_timer #(.W(DWELL_W)) u_dwell_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_c),
        .dec      (tmr_dec_c),
        .load_val (tmr_val_c),
        .expire   (tmr_expire)
    );

    // Next-state, next-output and timer control.
    always_comb begin
        state_d    = state_q;
        en_d       = 1'b0;
        a_d        = a;
        done_d     = 1'b0;
        wrap_d     = 1'b0;
        cap_c      = 1'b0;
        tmr_load_c = 1'b0;
        tmr_dec_c  = 1'b0;
        tmr_val_c  = dwell_q;
        nxt_addr_c = (a == last_q) ? first_q : ADDR_W'(a + 1'b1);

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    cap_c      = 1'b1;
                    state_d    = ST_DWELL;
                    en_d       = 1'b1;
                    a_d        = first_addr;
                    tmr_load_c = 1'b1;
                    tmr_val_c  = dwell;
                end
            end
            ST_DWELL: begin
                tmr_dec_c = 1'b1;
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (!tmr_expire) begin
                    en_d = 1'b1;
                end else if ((a == last_q) && !cont_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    wrap_d = (a == last_q);
                    if (GAP_EN) begin
                        state_d = ST_GAP;
                    end else begin
                        en_d       = 1'b1;
                        a_d        = nxt_addr_c;
                        tmr_load_c = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d    = ST_DWELL;
                    en_d       = 1'b1;
                    a_d        = nxt_addr_c;
                    tmr_load_c = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered decoder-facing outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            en      <= 1'b0;
            a       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state_q <= state_d;
            en      <= en_d;
            a       <= a_d;
            busy    <= (state_d != ST_IDLE);
            done    <= done_d;
            wrap    <= wrap_d;
        end
    end

    // Scan configuration is frozen at start so mid-scan input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q <= '0;
            last_q  <= '0;
            dwell_q <= '0;
            cont_q  <= 1'b0;
        end else if (cap_c) begin
            first_q <= first_addr;
            last_q  <= last_addr;
            dwell_q <= dwell;
            cont_q  <= cont;
        end
    end

endmodule

// File: tb/tb_decoder_addr_sequencer.sv
// Scoreboard bench: two sequencers (with and without blanking) share stimulus; a
// line-list reference model queues per-cycle expectations that a monitor consumes.
module tb_decoder_addr_sequencer;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 8;

    typedef struct packed {
        logic          en;
        logic [AW-1:0] a;
        logic          busy;
        logic          done;
        logic          wrap;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, stop = 1'b0, cont = 1'b0;
    logic [AW-1:0] first_addr = '0, last_addr = '0;
    logic [DW-1:0] dwell = '0;

    logic          en0, busy0, done0, wrap0;
    logic [AW-1:0] a0;
    logic          en1, busy1, done1, wrap1;
    logic [AW-1:0] a1;

    always #5 clk = ~clk;

    decoder_addr_sequencer #(.ADDR_W(AW), .DWELL_W(DW), .GAP_EN(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont),
        .first_addr(first_addr), .last_addr(last_addr), .dwell(dwell),
        .en(en0), .a(a0), .busy(busy0), .done(done0), .wrap(wrap0)
    );

    decoder_addr_sequencer #(.ADDR_W(AW), .DWELL_W(DW), .GAP_EN(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont),
        .first_addr(first_addr), .last_addr(last_addr), .dwell(dwell),
        .en(en1), .a(a1), .busy(busy1), .done(done1), .wrap(wrap1)
    );

    // Values applied at the next falling edge.
    logic          d_rst_n = 1'b0, d_start = 1'b0, d_stop = 1'b0, d_cont = 1'b0;
    logic [AW-1:0] d_first = '0, d_last = '0;
    logic [DW-1:0] d_dwell = '0;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;

    exp_t plan0[$], plan1[$], exp0[$], exp1[$];
    bit   m_busy[2];
    int   m_last_a[2];
    int   c_first[2], c_last[2], c_dwell[2];
    bit   c_cont[2];

    function automatic exp_t mk(input bit e, input int addr, input bit b, input bit d, input bit w);
        exp_t r;
        r.en = e; r.a = AW'(addr); r.busy = b; r.done = d; r.wrap = w;
        return r;
    endfunction

    task automatic plan_push(input int g, input exp_t e);
        if (g == 0) plan0.push_back(e); else plan1.push_back(e);
    endtask

    task automatic plan_pop(input int g, output exp_t e);
        if (g == 0) e = plan0.pop_front(); else e = plan1.pop_front();
    endtask

    function automatic int plan_size(input int g);
        return (g == 0) ? plan0.size() : plan1.size();
    endfunction

    task automatic plan_clear(input int g);
        if (g == 0) plan0.delete(); else plan1.delete();
    endtask

    task automatic exp_push(input int g, input exp_t e);
        if (g == 0) exp0.push_back(e); else exp1.push_back(e);
    endtask

    // One full pass over the line list; dut0 blanks between lines, dut1 does not.
    task automatic build_pass(input int g, input bit first_pass);
        int n, d, addr;
        bit gap;
        gap = (g == 0);
        n = ((c_last[g] - c_first[g]) & 63) + 1;
        d = (c_dwell[g] == 0) ? 1 : c_dwell[g];
        for (int i = 0; i < n; i++) begin
            addr = (c_first[g] + i) % 64;
            for (int k = 0; k < d; k++)
                plan_push(g, mk(1'b1, addr, 1'b1, 1'b0, !gap && !first_pass && i == 0 && k == 0));
            if (gap && i < n - 1)
                plan_push(g, mk(1'b0, addr, 1'b1, 1'b0, 1'b0));
        end
        if (!c_cont[g])
            plan_push(g, mk(1'b0, c_last[g], 1'b0, 1'b1, 1'b0));
        else if (gap)
            plan_push(g, mk(1'b0, c_last[g], 1'b1, 1'b0, 1'b1));
    endtask

    // Predict what each DUT shows after the coming rising edge.
    task automatic model_step();
        exp_t e;
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                plan_clear(g);
                m_busy[g]   = 1'b0;
                m_last_a[g] = 0;
            end else if (!m_busy[g]) begin
                if (start && !stop) begin
                    c_first[g] = int'(first_addr);
                    c_last[g]  = int'(last_addr);
                    c_dwell[g] = int'(dwell);
                    c_cont[g]  = cont;
                    build_pass(g, 1'b1);
                end
            end else if (stop) begin
                plan_clear(g);
            end else if (plan_size(g) == 0 && c_cont[g]) begin
                build_pass(g, 1'b0);
            end
            if (plan_size(g) > 0) plan_pop(g, e);
            else e = mk(1'b0, m_last_a[g], 1'b0, 1'b0, 1'b0);
            m_last_a[g] = int'(e.a);
            m_busy[g]   = e.busy;
            exp_push(g, e);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        rst_n = d_rst_n; start = d_start; stop = d_stop; cont = d_cont;
        first_addr = d_first; last_addr = d_last; dwell = d_dwell;
        model_step();
        mon_en = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cfg(input int f, input int l, input int d, input bit c);
        d_first = AW'(f); d_last = AW'(l); d_dwell = DW'(d); d_cont = c;
    endtask

    task automatic pulse_start();
        d_start = 1'b1; tick(); d_start = 1'b0;
    endtask

    task automatic pulse_stop();
        d_stop = 1'b1; tick(); d_stop = 1'b0;
    endtask

    task automatic mon_check(input int g, input exp_t act);
        exp_t e;
        logic [63:0] y;
        n_checks++;
        if ((g == 0 ? exp0.size() : exp1.size()) == 0) begin
            n_fail++;
            $display("FAIL sb_empty dut%0d t=%0t: output with no queued expectation", g, $time);
        end else begin
            if (g == 0) e = exp0.pop_front(); else e = exp1.pop_front();
            if (act !== e) begin
                n_fail++;
                $display("FAIL seq dut%0d t=%0t: got en=%b a=%0d busy=%b done=%b wrap=%b, expected en=%b a=%0d busy=%b done=%b wrap=%b",
                         g, $time, act.en, act.a, act.busy, act.done, act.wrap,
                         e.en, e.a, e.busy, e.done, e.wrap);
            end
        end
        y = act.en ? (64'd1 << act.a) : 64'd0;
        n_checks++;
        if ($countones(y) > 1 || (act.en && !act.busy)) begin
            n_fail++;
            $display("FAIL onehot dut%0d t=%0t: got %0d lines selected with busy=%b, expected <=1 line and en only while busy",
                     g, $time, $countones(y), act.busy);
        end
    endtask

    // Monitor: compare both DUTs shortly after every rising edge.
    always begin
        @(posedge clk);
        #1;
        if (mon_en) begin
            mon_check(0, {en0, a0, busy0, done0, wrap0});
            mon_check(1, {en1, a1, busy1, done1, wrap1});
        end
    end

    task automatic check_zero(input int g, input exp_t act);
        n_checks++;
        if (act !== '0) begin
            n_fail++;
            $display("FAIL async_reset dut%0d t=%0t: got en=%b a=%0d busy=%b done=%b wrap=%b, expected all zero",
                     g, $time, act.en, act.a, act.busy, act.done, act.wrap);
        end
    endtask

    // Drop rst_n between edges and check outputs clear without a clock.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_zero(0, {en0, a0, busy0, done0, wrap0});
        check_zero(1, {en1, a1, busy1, done1, wrap1});
        exp0.delete();
        exp1.delete();
        for (int g = 0; g < 2; g++) begin
            plan_clear(g);
            m_busy[g]   = 1'b0;
            m_last_a[g] = 0;
            exp_push(g, mk(1'b0, 0, 1'b0, 1'b0, 1'b0));
        end
        d_rst_n = 1'b0;
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            m_busy[g] = 1'b0; m_last_a[g] = 0;
            c_first[g] = 0; c_last[g] = 0; c_dwell[g] = 0; c_cont[g] = 1'b0;
        end
        run(2);
        d_rst_n = 1'b1;
        run(3);

        // Short scan with blanking, then a scan wrapping through 63->0.
        cfg(5, 7, 2, 1'b0);   pulse_start(); run(16);
        cfg(62, 1, 1, 1'b0);  pulse_start(); run(12);

        // Continuous single-line scan, then abort.
        cfg(10, 10, 3, 1'b1); pulse_start(); run(13);
        pulse_stop(); run(3);

        // dwell=0 behaves as one cycle per line.
        cfg(20, 23, 0, 1'b0); pulse_start(); run(12);

        // Mid-scan config changes and restart attempts; start+stop in idle.
        cfg(0, 5, 2, 1'b0);   pulse_start(); run(3);
        cfg(40, 50, 7, 1'b1); pulse_start(); run(25);
        d_stop = 1'b1; pulse_start(); d_stop = 1'b0; run(3);

        // Reset in the middle of a dwell.
        cfg(8, 12, 4, 1'b1);  pulse_start(); run(2);
        async_reset();
        run(2);
        d_rst_n = 1'b1;
        cfg(1, 2, 1, 1'b1);   run(5);

        // Randomised scans with stray starts, stops and config churn.
        for (int it = 0; it < 40; it++) begin
            int f, len;
            f = $urandom_range(0, 63);
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 5);
            cfg(f, (f + len) % 64, $urandom_range(0, 3), $urandom_range(0, 1));
            d_stop = ($urandom_range(0, 7) == 0);
            pulse_start();
            d_stop = 1'b0;
            for (int c = 0, n = $urandom_range(5, 60); c < n; c++) begin
                d_start = ($urandom_range(0, 9) == 0);
                d_stop  = ($urandom_range(0, 24) == 0);
                if ($urandom_range(0, 3) == 0)
                    cfg($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 9), $urandom_range(0, 1));
                tick();
            end
            d_start = 1'b0;
            pulse_stop();
            run(2);
        end

        @(posedge clk);
        #2;
        n_checks++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d/%0d expectations left, expected 0/0", exp0.size(), exp1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
